// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller:
// forward-select encodings and the memory-wait FSM states.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_MEM   = 2'd1,
    FWD_WB    = 2'd2,
    FWD_WBREG = 2'd3
  } fwd_sel_e;

  typedef enum logic {
    StRun  = 1'b0,
    StWait = 1'b1
  } state_e;

  // A WB-slot producer is read straight from the regfile when it writes through.
  function automatic fwd_sel_e wb_fwd_sel(input bit rf_bypass);
    return rf_bypass ? FWD_RF : FWD_WBREG;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-stage hazard inputs, data-memory handshake and pipeline control outputs.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned PERF_W = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_ra_addr;
  logic [REG_AW-1:0] id_rt_addr;
  logic              id_ra_used;
  logic              id_rt_used;
  logic [REG_AW-1:0] id_wr_addr;
  logic              id_reg_write;
  logic              id_is_load;
  logic              id_mem_acc;
  logic              id_br_taken;
  logic              dm_ready;
  logic              freeze;
  logic              stall_if_id;
  logic              bubble_id_ex;
  logic              flush_if_id;
  logic [1:0]        fwd_ra_sel;
  logic [1:0]        fwd_rt_sel;
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] freeze_cnt;

  modport master (
    output id_valid, id_ra_addr, id_rt_addr, id_ra_used, id_rt_used, id_wr_addr,
           id_reg_write, id_is_load, id_mem_acc, id_br_taken, dm_ready,
    input  freeze, stall_if_id, bubble_id_ex, flush_if_id, fwd_ra_sel, fwd_rt_sel,
           stall_cnt, freeze_cnt
  );

  modport slave (
    input  id_valid, id_ra_addr, id_rt_addr, id_ra_used, id_rt_used, id_wr_addr,
           id_reg_write, id_is_load, id_mem_acc, id_br_taken, dm_ready,
    output freeze, stall_if_id, bubble_id_ex, flush_if_id, fwd_ra_sel, fwd_rt_sel,
           stall_cnt, freeze_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_slot.sv
// One shadow-scoreboard slot: records an in-flight instruction's destination info.
module pipe_hazard_ctrl_hazard_slot #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hold,
  input  logic              clear,
  input  logic              d_valid,
  input  logic              d_wr,
  input  logic [REG_AW-1:0] d_addr,
  input  logic              d_load,
  input  logic              d_mem,
  output logic              q_valid,
  output logic              q_wr,
  output logic [REG_AW-1:0] q_addr,
  output logic              q_load,
  output logic              q_mem
);

  // Hold wins over clear so a frozen pipe keeps its contents intact.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_valid <= 1'b0;
      q_wr    <= 1'b0;
      q_addr  <= '0;
      q_load  <= 1'b0;
      q_mem   <= 1'b0;
    end else if (!hold) begin
      if (clear) begin
        q_valid <= 1'b0;
        q_wr    <= 1'b0;
        q_addr  <= '0;
        q_load  <= 1'b0;
        q_mem   <= 1'b0;
      end else begin
        q_valid <= d_valid;
        q_wr    <= d_wr;
        q_addr  <= d_addr;
        q_load  <= d_load;
        q_mem   <= d_mem;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage core: load-use bubbles, branch flush,
// registered forward selects and a pipe freeze while data memory is not ready.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned RF_BYPASS = 1,
  parameter int unsigned ZERO_REG  = 0,
  parameter int unsigned PERF_W    = 16
) (
  input logic               clock,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);

  logic              ex_valid, ex_wr, ex_load, ex_mem;
  logic              mem_valid, mem_wr, mem_load, mem_mem;
  logic              wb_valid, wb_wr, wb_load, wb_mem;
  logic [REG_AW-1:0] ex_addr, mem_addr, wb_addr;

  state_e            state_q, state_d;
  logic              mem_pending, freeze, load_use, bubble, stall;
  logic              ra_ex, ra_mem, ra_wb, rt_ex, rt_mem, rt_wb;
  fwd_sel_e          ra_sel_d, rt_sel_d;
  logic [1:0]        ra_sel_q, rt_sel_q;
  logic [PERF_W-1:0] stall_cnt_q, freeze_cnt_q;
  logic              unused_wb;

  function automatic logic hit(input logic used, input logic v, input logic wr,
                               input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] dst);
    return used && v && wr && (src == dst) && !((ZERO_REG != 0) && (src == '0));
  endfunction

  // Youngest producer wins.
  function automatic fwd_sel_e pick(input logic h_ex, input logic h_mem, input logic h_wb);
    if (h_ex)  return FWD_MEM;
    if (h_mem) return FWD_WB;
    if (h_wb)  return wb_fwd_sel(RF_BYPASS != 0);
    return FWD_RF;
  endfunction

  pipe_hazard_ctrl_hazard_slot #(.REG_AW(REG_AW)) u_slot_ex (
    .clock  (clock),           .reset  (reset),
    .hold   (freeze),          .clear  (bubble),
    .d_valid(bus.id_valid),    .d_wr   (bus.id_reg_write), .d_addr (bus.id_wr_addr),
    .d_load (bus.id_is_load),  .d_mem  (bus.id_mem_acc),
    .q_valid(ex_valid),        .q_wr   (ex_wr),            .q_addr (ex_addr),
    .q_load (ex_load),         .q_mem  (ex_mem)
  );

  pipe_hazard_ctrl_hazard_slot #(.REG_AW(REG_AW)) u_slot_mem (
    .clock  (clock),     .reset  (reset),
    .hold   (freeze),    .clear  (1'b0),
    .d_valid(ex_valid),  .d_wr   (ex_wr),   .d_addr (ex_addr),
    .d_load (ex_load),   .d_mem  (ex_mem),
    .q_valid(mem_valid), .q_wr   (mem_wr),  .q_addr (mem_addr),
    .q_load (mem_load),  .q_mem  (mem_mem)
  );

  pipe_hazard_ctrl_hazard_slot #(.REG_AW(REG_AW)) u_slot_wb (
    .clock  (clock),     .reset  (reset),
    .hold   (freeze),    .clear  (1'b0),
    .d_valid(mem_valid), .d_wr   (mem_wr),  .d_addr (mem_addr),
    .d_load (mem_load),  .d_mem  (mem_mem),
    .q_valid(wb_valid),  .q_wr   (wb_wr),   .q_addr (wb_addr),
    .q_load (wb_load),   .q_mem  (wb_mem)
  );

  assign unused_wb = wb_load ^ wb_mem;

  assign ra_ex  = hit(bus.id_ra_used, ex_valid,  ex_wr,  bus.id_ra_addr, ex_addr);
  assign ra_mem = hit(bus.id_ra_used, mem_valid, mem_wr, bus.id_ra_addr, mem_addr);
  assign ra_wb  = hit(bus.id_ra_used, wb_valid,  wb_wr,  bus.id_ra_addr, wb_addr);
  assign rt_ex  = hit(bus.id_rt_used, ex_valid,  ex_wr,  bus.id_rt_addr, ex_addr);
  assign rt_mem = hit(bus.id_rt_used, mem_valid, mem_wr, bus.id_rt_addr, mem_addr);
  assign rt_wb  = hit(bus.id_rt_used, wb_valid,  wb_wr,  bus.id_rt_addr, wb_addr);

  assign ra_sel_d = pick(ra_ex, ra_mem, ra_wb);
  assign rt_sel_d = pick(rt_ex, rt_mem, rt_wb);

  // The access stays held in MEM during WAIT, so freeze drops the cycle dm_ready rises.
  assign mem_pending = mem_valid && mem_mem;
  assign freeze      = ((state_q == StWait) || mem_pending) && !bus.dm_ready;
  assign load_use    = (ra_ex || rt_ex) && ex_load;
  assign bubble      = load_use && !freeze;
  assign stall       = freeze || load_use;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:   if (mem_pending && !bus.dm_ready) state_d = StWait;
      StWait:  if (bus.dm_ready) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StRun;
      ra_sel_q     <= FWD_RF;
      rt_sel_q     <= FWD_RF;
      stall_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (!freeze) begin
        ra_sel_q <= bubble ? FWD_RF : ra_sel_d;
        rt_sel_q <= bubble ? FWD_RF : rt_sel_d;
      end
      if (bubble && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      if (freeze && (freeze_cnt_q != '1)) freeze_cnt_q <= freeze_cnt_q + PERF_W'(1);
    end
  end

  assign bus.freeze       = freeze;
  assign bus.stall_if_id  = stall;
  assign bus.bubble_id_ex = bubble;
  assign bus.flush_if_id  = bus.id_valid && bus.id_br_taken && !stall;
  assign bus.fwd_ra_sel   = ra_sel_q;
  assign bus.fwd_rt_sel   = rt_sel_q;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.freeze_cnt   = freeze_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: dut_a uses defaults; dut_b (RF_BYPASS=0, ZERO_REG=1, PERF_W=2) sees the
// same stimulus and covers WB-register forwarding, r0 exclusion and counter saturation.
module tb_pipe_hazard_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_total = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  pipe_hazard_ctrl_if #(.REG_AW(5), .PERF_W(16)) bus_a ();
  pipe_hazard_ctrl_if #(.REG_AW(5), .PERF_W(2))  bus_b ();

  assign bus_b.id_valid     = bus_a.id_valid;
  assign bus_b.id_ra_addr   = bus_a.id_ra_addr;
  assign bus_b.id_rt_addr   = bus_a.id_rt_addr;
  assign bus_b.id_ra_used   = bus_a.id_ra_used;
  assign bus_b.id_rt_used   = bus_a.id_rt_used;
  assign bus_b.id_wr_addr   = bus_a.id_wr_addr;
  assign bus_b.id_reg_write = bus_a.id_reg_write;
  assign bus_b.id_is_load   = bus_a.id_is_load;
  assign bus_b.id_mem_acc   = bus_a.id_mem_acc;
  assign bus_b.id_br_taken  = bus_a.id_br_taken;
  assign bus_b.dm_ready     = bus_a.dm_ready;

  pipe_hazard_ctrl #(.REG_AW(5), .RF_BYPASS(1), .ZERO_REG(0), .PERF_W(16)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .RF_BYPASS(0), .ZERO_REG(1), .PERF_W(2)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] ra, input logic ra_u,
                       input logic [4:0] rt, input logic rt_u, input logic [4:0] wa,
                       input logic rw, input logic ld, input logic ma, input logic br);
    bus_a.id_valid     = v;
    bus_a.id_ra_addr   = ra;
    bus_a.id_ra_used   = ra_u;
    bus_a.id_rt_addr   = rt;
    bus_a.id_rt_used   = rt_u;
    bus_a.id_wr_addr   = wa;
    bus_a.id_reg_write = rw;
    bus_a.id_is_load   = ld;
    bus_a.id_mem_acc   = ma;
    bus_a.id_br_taken  = br;
    #1;
  endtask

  task automatic nop();                                   drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic alu(input logic [4:0] wa, input logic [4:0] ra);  drive(1, ra, 1, 0, 0, wa, 1, 0, 0, 0); endtask
  task automatic lwi(input logic [4:0] wa, input logic [4:0] ra);  drive(1, ra, 1, 0, 0, wa, 1, 1, 1, 0); endtask
  task automatic sw(input logic [4:0] ra, input logic [4:0] rt);   drive(1, ra, 1, rt, 1, 0, 0, 0, 1, 0); endtask
  task automatic beq(input logic [4:0] ra, input logic [4:0] rt);  drive(1, ra, 1, rt, 1, 0, 0, 0, 0, 1); endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) begin
      nop();
      tick();
    end
  endtask

  initial begin
    bus_a.dm_ready = 1'b1;
    nop();
    #10;
    check("rst_freeze", 32'(bus_a.freeze), 0);
    check("rst_stall",  32'(bus_a.stall_if_id), 0);
    check("rst_bubble", 32'(bus_a.bubble_id_ex), 0);
    check("rst_flush",  32'(bus_a.flush_if_id), 0);
    check("rst_ra_sel", 32'(bus_a.fwd_ra_sel), 0);
    check("rst_scnt",   32'(bus_a.stall_cnt), 0);
    reset = 1'b1;
    tick();

    // Back-to-back dependency: EX-slot forward, no stall.
    alu(1, 5);        tick();
    alu(2, 1);
    check("b2b_stall", 32'(bus_a.stall_if_id), 0);
    tick(); nop();
    check("b2b_sel_a", 32'(bus_a.fwd_ra_sel), 1);
    check("b2b_sel_b", 32'(bus_b.fwd_ra_sel), 1);
    drain();

    // One-instruction gap: MEM-slot forward.
    alu(1, 5); tick(); nop(); tick(); alu(2, 1); tick(); nop();
    check("gap_sel", 32'(bus_a.fwd_ra_sel), 2);
    drain();

    // Two-instruction gap: WB-slot hit.
    alu(1, 5); tick(); nop(); tick(); nop(); tick(); alu(2, 1); tick(); nop();
    check("wb_sel_bypass", 32'(bus_a.fwd_ra_sel), 0);
    check("wb_sel_wbreg",  32'(bus_b.fwd_ra_sel), 3);
    drain();

    // Load-use: one bubble, then MEM forward.
    lwi(3, 5); tick();
    alu(4, 3);
    check("lu_stall",  32'(bus_a.stall_if_id), 1);
    check("lu_bubble", 32'(bus_a.bubble_id_ex), 1);
    tick(); alu(4, 3);
    check("lu_stall2",  32'(bus_a.stall_if_id), 0);
    check("lu_bubble2", 32'(bus_a.bubble_id_ex), 0);
    check("lu_scnt",    32'(bus_a.stall_cnt), 1);
    check("lu_bub_sel", 32'(bus_a.fwd_ra_sel), 0);
    tick(); nop();
    check("lu_sel", 32'(bus_a.fwd_ra_sel), 2);
    drain();

    // Store waits three cycles on dm_ready.
    sw(5, 6); tick(); alu(7, 9); tick();
    bus_a.dm_ready = 1'b0;
    alu(8, 7);
    check("frz_on",     32'(bus_a.freeze), 1);
    check("frz_stall",  32'(bus_a.stall_if_id), 1);
    check("frz_bubble", 32'(bus_a.bubble_id_ex), 0);
    tick();
    check("frz_wait1", 32'(bus_a.freeze), 1);
    tick();
    check("frz_wait2", 32'(bus_a.freeze), 1);
    check("frz_cnt2",  32'(bus_a.freeze_cnt), 2);
    tick();
    bus_a.dm_ready = 1'b1;
    #1;
    check("frz_off",      32'(bus_a.freeze), 0);
    check("frz_cnt3",     32'(bus_a.freeze_cnt), 3);
    check("frz_sel_held", 32'(bus_a.fwd_ra_sel), 0);
    tick(); nop();
    check("frz_slots_held", 32'(bus_a.fwd_ra_sel), 1);
    check("frz_cnt_keep",   32'(bus_a.freeze_cnt), 3);
    drain();

    // Zero wait states, then two more wait cycles to saturate dut_b's counter.
    sw(5, 6); tick(); nop(); tick();
    check("zw_nofrz", 32'(bus_a.freeze), 0);
    drain();
    sw(5, 6); tick(); nop(); tick();
    bus_a.dm_ready = 1'b0;
    #1;
    tick(); tick();
    bus_a.dm_ready = 1'b1;
    #1;
    check("sat_cnt_a", 32'(bus_a.freeze_cnt), 5);
    check("sat_cnt_b", 32'(bus_b.freeze_cnt), 3);
    drain();

    // Taken branch, no hazard.
    beq(10, 11);
    check("br_flush", 32'(bus_a.flush_if_id), 1);
    tick(); nop();
    check("br_flush_1cyc", 32'(bus_a.flush_if_id), 0);
    drain();

    // Taken branch dependent on a load: stall first, flush after.
    lwi(12, 5); tick();
    beq(10, 12);
    check("brlu_stall", 32'(bus_a.stall_if_id), 1);
    check("brlu_noflush", 32'(bus_a.flush_if_id), 0);
    tick(); beq(10, 12);
    check("brlu_flush", 32'(bus_a.flush_if_id), 1);
    tick(); nop();
    check("brlu_flush_off", 32'(bus_a.flush_if_id), 0);
    check("brlu_rt_sel",    32'(bus_a.fwd_rt_sel), 2);
    check("brlu_scnt",      32'(bus_a.stall_cnt), 2);
    drain();

    // r0 producer/consumer: hardwired only in dut_b.
    alu(0, 5); tick(); alu(4, 0); tick(); nop();
    check("r0_sel_a", 32'(bus_a.fwd_ra_sel), 1);
    check("r0_sel_b", 32'(bus_b.fwd_ra_sel), 0);
    drain();
    lwi(0, 5); tick(); alu(4, 0);
    check("r0_lu_a", 32'(bus_a.stall_if_id), 1);
    check("r0_lu_b", 32'(bus_b.stall_if_id), 0);
    tick();
    drain();
    check("r0_scnt_a", 32'(bus_a.stall_cnt), 3);
    check("r0_scnt_b", 32'(bus_b.stall_cnt), 2);

    // Reset asserted while waiting on memory.
    sw(5, 6); tick(); nop(); tick();
    bus_a.dm_ready = 1'b0;
    #1;
    tick();
    check("rw_frz", 32'(bus_a.freeze), 1);
    #1;
    reset = 1'b0;
    #1;
    check("rw_frz_a",  32'(bus_a.freeze), 0);
    check("rw_frz_b",  32'(bus_b.freeze), 0);
    check("rw_stall",  32'(bus_a.stall_if_id), 0);
    check("rw_sel",    32'(bus_a.fwd_ra_sel), 0);
    check("rw_fcnt",   32'(bus_a.freeze_cnt), 0);
    check("rw_scnt",   32'(bus_a.stall_cnt), 0);
    #2;
    reset = 1'b1;
    tick();
    check("rw_run", 32'(bus_a.freeze), 0);
    bus_a.dm_ready = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
